// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
//   Direction controller between debounced key pulses and the snake movement
//   logic. Picks one key per cycle (up > down > left > right), rejects repeats
//   and reversals against the most recent pending direction, buffers legal
//   turns in a small circular queue, and applies one queued turn per step tick.
//
// Parameters
//   QDEPTH    turn-queue depth, 1..4
//   INIT_DIR  direction loaded at reset and on game_clr
//
// Ports
//   Clk        system clock
//   Rst_n      asynchronous active-low reset
//   key_flag   [3:0] one-cycle press pulses: bit0 up, bit1 down, bit2 left, bit3 right
//   step_tick  one-cycle pulse, snake advances one cell
//   game_clr   synchronous clear: flush queue, load INIT_DIR
//   dir        [1:0] current direction: 00 up, 01 down, 10 left, 11 right
//   dir_chg    pulse: dir took a new value this cycle
//   q_cnt      [2:0] number of queued turns
//   key_acc    pulse: a press was queued
//   key_rej    pulse: a press was dropped
module snake_dir_ctrl #(
  parameter int unsigned QDEPTH   = 2,
  parameter logic [1:0]  INIT_DIR = 2'b11
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [3:0] key_flag,
  input  logic       step_tick,
  input  logic       game_clr,
  output logic [1:0] dir,
  output logic       dir_chg,
  output logic [2:0] q_cnt,
  output logic       key_acc,
  output logic       key_rej
);

  localparam logic [2:0] DEPTH_C = 3'(QDEPTH);
  localparam logic [1:0] LAST_C  = 2'(QDEPTH - 1);

  // Storage sized for the maximum depth so a 2-bit pointer indexes it exactly.
  logic [1:0] mem_q [4];

  logic [1:0] rptr_q, rptr_d;
  logic [1:0] wptr_q, wptr_d;
  logic [2:0] cnt_q,  cnt_d;
  logic [1:0] dir_q,  dir_d;
  logic       chg_q,  chg_d;
  logic       acc_q,  acc_d;
  logic       rej_q,  rej_d;

  logic       key_vld;
  logic [1:0] key_dir;
  logic [1:0] tail_ptr;
  logic [1:0] ref_dir;
  logic       legal;
  logic       pop;
  logic       push;

  // Arbitration, legality and push/pop decisions.
  always_comb begin
    key_vld = |key_flag;
    key_dir = 2'b11;
    if (key_flag[0])      key_dir = 2'b00;
    else if (key_flag[1]) key_dir = 2'b01;
    else if (key_flag[2]) key_dir = 2'b10;
    else                  key_dir = 2'b11;

    tail_ptr = (wptr_q == '0) ? LAST_C : wptr_q - 2'd1;
    // Newest pending direction; with a simultaneous pop at q_cnt = 1 the tail
    // is the entry moving into dir, so the pre-pop tail is still correct.
    ref_dir  = (cnt_q != '0) ? mem_q[tail_ptr] : dir_q;
    // Reversal differs from the reference only in bit0.
    legal    = (key_dir != ref_dir) && (key_dir != (ref_dir ^ 2'b01));
    pop      = step_tick && (cnt_q != '0);
    push     = key_vld && legal && ((cnt_q < DEPTH_C) || pop);
  end

  // Next-state for pointers, count, direction and status pulses.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    chg_d  = 1'b0;
    acc_d  = 1'b0;
    rej_d  = 1'b0;

    if (game_clr) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
      dir_d  = INIT_DIR;
    end else begin
      if (pop) begin
        dir_d  = mem_q[rptr_q];
        chg_d  = 1'b1;
        rptr_d = (rptr_q == LAST_C) ? '0 : rptr_q + 2'd1;
      end
      if (push) begin
        wptr_d = (wptr_q == LAST_C) ? '0 : wptr_q + 2'd1;
        acc_d  = 1'b1;
      end else if (key_vld) begin
        rej_d  = 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 3'd1;
        2'b01:   cnt_d = cnt_q - 3'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      dir_q  <= INIT_DIR;
      chg_q  <= 1'b0;
      acc_q  <= 1'b0;
      rej_q  <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      chg_q  <= chg_d;
      acc_q  <= acc_d;
      rej_q  <= rej_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
    end else if (push && !game_clr) begin
      mem_q[wptr_q] <= key_dir;
    end
  end

  assign dir     = dir_q;
  assign dir_chg = chg_q;
  assign q_cnt   = cnt_q;
  assign key_acc = acc_q;
  assign key_rej = rej_q;

endmodule
